// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared state encoding for the multi-port register file family.
package regfile_mp_pkg;
    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port with zero-register, bypass and clear-phase masking.
module regfile_rdport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]     ra_i,
    input  logic [NWR-1:0]        we_i,
    input  logic [NWR*ADDR_W-1:0] wa_i,
    input  logic [NWR*DATA_W-1:0] wd_i,
    input  logic [DATA_W-1:0]     word_i,
    input  logic                  ready_i,
    output logic [DATA_W-1:0]     rd_o
);
    // we_i carries only writes that will land, so the highest hitting port is forwarded
    always_comb begin
        rd_o = word_i;
        for (int k = 0; k < NWR; k++)
            if (BYPASS != 0 && we_i[k] && wa_i[k*ADDR_W +: ADDR_W] == ra_i) rd_o = wd_i[k*DATA_W +: DATA_W];
        if (!ready_i || (ZERO_REG != 0 && ra_i == '0)) rd_o = '0;
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / NWR-write register file with post-reset clear walk and collision flag.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*ADDR_W-1:0] wa,
    input  logic [NWR*DATA_W-1:0] wd,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic                  ready,
    output logic                  wr_conflict
);
    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] rf_q [NREGS];
    logic              state_q;
    logic [ADDR_W-1:0] clr_ptr_q;
    logic              ready_q;
    logic              conflict_q;
    logic              conflict_d;
    logic [NWR-1:0]    we_eff;

    // writes to a hardwired zero register are dropped before they can collide or bypass
    always_comb begin
        we_eff = we;
        for (int k = 0; k < NWR; k++)
            if (ZERO_REG != 0 && wa[k*ADDR_W +: ADDR_W] == '0) we_eff[k] = 1'b0;
        conflict_d = 1'b0;
        for (int i = 0; i < NWR; i++)
            for (int j = i + 1; j < NWR; j++)
                if (we_eff[i] && we_eff[j] && wa[i*ADDR_W +: ADDR_W] == wa[j*ADDR_W +: ADDR_W]) conflict_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            clr_ptr_q  <= '0;
            ready_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else if (state_q == ST_INIT) begin
            rf_q[clr_ptr_q] <= '0;
            clr_ptr_q       <= clr_ptr_q + 1'b1;
            conflict_q      <= 1'b0;
            if (clr_ptr_q == ADDR_W'(NREGS - 1)) begin
                state_q <= ST_RUN;
                ready_q <= 1'b1;
            end
        end else begin
            for (int k = 0; k < NWR; k++)
                if (we_eff[k]) rf_q[wa[k*ADDR_W +: ADDR_W]] <= wd[k*DATA_W +: DATA_W];
            conflict_q <= conflict_d;
        end
    end

    assign ready       = ready_q;
    assign wr_conflict = conflict_q;

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        regfile_rdport #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NWR(NWR), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
        ) u_rdport (
            .ra_i    (ra[j*ADDR_W +: ADDR_W]),
            .we_i    (we_eff),
            .wa_i    (wa),
            .wd_i    (wd),
            .word_i  (rf_q[ra[j*ADDR_W +: ADDR_W]]),
            .ready_i (ready_q),
            .rd_o    (rd[j*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of a bypassing and a non-bypassing two-write-port file driven in lockstep.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [9:0]  ra;
    logic [63:0] rd_b, rd_n;
    logic        ready_b, ready_n, conf_b, conf_n;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp #(.NWR(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd_b), .ready(ready_b), .wr_conflict(conf_b)
    );

    regfile_mp #(.NWR(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd_n), .ready(ready_n), .wr_conflict(conf_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(input string tag);
        for (int i = 0; i < 31; i++) begin
            tick();
            check({tag, "_ready_lo_b"}, 32'(ready_b), 32'd0);
            check({tag, "_ready_lo_n"}, 32'(ready_n), 32'd0);
        end
        tick();
        check({tag, "_ready_hi_b"}, 32'(ready_b), 32'd1);
        check({tag, "_ready_hi_n"}, 32'(ready_n), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; we = '0; wa = '0; wd = '0; ra = '0;
        repeat (2) tick();
        check("rst_ready", 32'(ready_b), 32'd0);
        check("rst_conf", 32'(conf_b), 32'd0);
        rst_n = 1'b1;
        // write attempted during the clear walk must never land nor bypass
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEADBEEF}; ra = {5'd0, 5'd5};
        #1;
        check("init_rd_masked", rd_b[31:0], 32'd0);
        wait_clear("clr1");
        we = 2'b00;
        #1;
        check("init_write_dropped", rd_b[31:0], 32'd0);
        for (int i = 0; i < 32; i++) begin
            ra = {5'(31 - i), 5'(i)};
            #1;
            check("clear_rd0", rd_b[31:0], 32'd0);
            check("clear_rd1", rd_n[63:32], 32'd0);
        end
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEADBEEF}; ra = {5'd0, 5'd5};
        #1;
        check("t2_bypass", rd_b[31:0], 32'hDEADBEEF);
        check("t2_nobypass", rd_n[31:0], 32'd0);
        tick();
        we = 2'b00;
        #1;
        check("t2_stored_b", rd_b[31:0], 32'hDEADBEEF);
        check("t2_stored_n", rd_n[31:0], 32'hDEADBEEF);
        we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'd0, 32'hFFFFFFFF}; ra = {5'd0, 5'd0};
        #1;
        check("t5_zero_same", rd_b[31:0], 32'd0);
        tick();
        check("t5_zero_conf", 32'(conf_b), 32'd0);
        we = 2'b11; wa = {5'd0, 5'd0}; wd = {32'h1, 32'h2};
        #1;
        check("t5_zero_next", rd_b[31:0], 32'd0);
        check("t5_zero_next_n", rd_n[31:0], 32'd0);
        tick();
        we = 2'b00;
        #1;
        check("t5_dual_zero_conf", 32'(conf_b), 32'd0);
        check("t5_dual_zero_rd", rd_b[31:0], 32'd0);
        we = 2'b01; wa = {5'd0, 5'd7}; wd = {32'd0, 32'h1234}; ra = {5'd7, 5'd0};
        #1;
        check("t4_bypass", rd_b[63:32], 32'h1234);
        check("t4_nobypass_old", rd_n[63:32], 32'd0);
        tick();
        we = 2'b00;
        #1;
        check("t4_nobypass_next", rd_n[63:32], 32'h1234);
        we = 2'b11; wa = {5'd3, 5'd3}; wd = {32'hB, 32'hA}; ra = {5'd0, 5'd3};
        #1;
        check("t6_bypass_win", rd_b[31:0], 32'hB);
        check("t6_nobypass_old", rd_n[31:0], 32'd0);
        check("t6_conf_before", 32'(conf_b), 32'd0);
        tick();
        we = 2'b00;
        #1;
        check("t6_conf_b", 32'(conf_b), 32'd1);
        check("t6_conf_n", 32'(conf_n), 32'd1);
        check("t6_stored_b", rd_b[31:0], 32'hB);
        check("t6_stored_n", rd_n[31:0], 32'hB);
        tick();
        check("t6_conf_pulse", 32'(conf_b), 32'd0);
        we = 2'b11; wa = {5'd9, 5'd8}; wd = {32'h22, 32'h11}; ra = {5'd9, 5'd8};
        tick();
        we = 2'b00;
        #1;
        check("dual_conf", 32'(conf_b), 32'd0);
        check("dual_rd8", rd_n[31:0], 32'h11);
        check("dual_rd9", rd_n[63:32], 32'h22);
        rst_n = 1'b0; ra = {5'd3, 5'd5};
        tick();
        rst_n = 1'b1;
        check("t7_ready_drop", 32'(ready_b), 32'd0);
        check("t7_rd_masked", rd_b[31:0], 32'd0);
        wait_clear("clr2");
        check("t7_r5_b", rd_b[31:0], 32'd0);
        check("t7_r5_n", rd_n[31:0], 32'd0);
        check("t7_r3_n", rd_n[63:32], 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
